// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_queue
// Purpose  : In-order queue of outstanding branch predictions. Each pushed
//            entry holds {pc, predicted direction}. When the oldest branch
//            resolves, its predicted direction is compared with the actual
//            one. A mismatch raises a registered one-cycle mispredict pulse
//            and records the PC. Resolved and mispredicted branches are
//            counted with saturating counters.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH            number of in-flight entries (power of two, >= 2)
//   PC_W             branch PC width
//   CNT_W            statistics counter width
// Ports
//   clock            in   1        rising-edge clock
//   reset            in   1        synchronous, active-low reset
//   pred_valid       in   1        prediction offered
//   pred_pc          in   PC_W     PC of predicted branch
//   pred_taken       in   1        predicted direction
//   pred_ready       out  1        queue not full
//   res_valid        in   1        oldest branch resolved
//   res_taken        in   1        actual direction
//   res_ready        out  1        queue not empty
//   flush            in   1        discard all outstanding entries
//   mispredict       out  1        one-cycle pulse after a mispredicting pop
//   mispredict_pc    out  PC_W     PC of most recent mispredicted branch
//   occupancy        out  log2+1   number of valid entries
//   total_count      out  CNT_W    resolved branches (saturating)
//   mispredict_count out  CNT_W    mispredicted branches (saturating)
// ============================================================================
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       pred_valid,
  input  logic [PC_W-1:0]            pred_pc,
  input  logic                       pred_taken,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       res_ready,
  input  logic                       flush,
  output logic                       mispredict,
  output logic [PC_W-1:0]            mispredict_pc,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           total_count,
  output logic [CNT_W-1:0]           mispredict_count
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Entry storage: no reset needed, validity is tracked by the pointers.
  logic [PC_W-1:0]  pc_mem_q [DEPTH];
  logic             tk_mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic             mis_q, mis_d;
  logic [PC_W-1:0]  mis_pc_q, mis_pc_d;
  logic [CNT_W-1:0] tot_q, tot_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic             w_push;
  logic             w_pop;
  logic             w_wrong;

  // Ready flags come from registered occupancy only, so a pop in the same
  // cycle never frees a slot for a push (no bypass).
  assign pred_ready = (occ_q != FULL_OCC);
  assign res_ready  = (occ_q != '0);

  assign w_push  = pred_valid && pred_ready && !flush;
  assign w_pop   = res_valid && res_ready && !flush;
  assign w_wrong = (tk_mem_q[rd_ptr_q] != res_taken);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    mis_d    = 1'b0;
    mis_pc_d = mis_pc_q;
    tot_d    = tot_q;
    mcnt_d   = mcnt_q;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (tot_q != CNT_MAX) begin
        tot_d = tot_q + 1'b1;
      end
      if (w_wrong) begin
        mis_d    = 1'b1;
        mis_pc_d = pc_mem_q[rd_ptr_q];
        if (mcnt_q != CNT_MAX) begin
          mcnt_d = mcnt_q + 1'b1;
        end
      end
    end

    case ({w_push, w_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    // Flush empties the queue; push/pop are already suppressed above, so
    // counters and the captured PC keep their values.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      mis_q    <= 1'b0;
      mis_pc_q <= '0;
      tot_q    <= '0;
      mcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      mis_q    <= mis_d;
      mis_pc_q <= mis_pc_d;
      tot_q    <= tot_d;
      mcnt_q   <= mcnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push && reset) begin
      pc_mem_q[wr_ptr_q] <= pred_pc;
      tk_mem_q[wr_ptr_q] <= pred_taken;
    end
  end

  assign mispredict       = mis_q;
  assign mispredict_pc    = mis_pc_q;
  assign occupancy        = occ_q;
  assign total_count      = tot_q;
  assign mispredict_count = mcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_queue
// Purpose  : Self-checking bench for branch_resolve_queue. Directed stimulus
//            drives a behavioural queue model; expected mispredict pulses are
//            queued at issue time and a negedge monitor pops and compares
//            them, together with occupancy, ready flags and counters.
//            Scenario checks use hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_queue;

  localparam int DEPTH = 8;
  localparam int PC_W  = 10;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic            clock;
  logic            reset;
  logic            pred_valid;
  logic [PC_W-1:0] pred_pc;
  logic            pred_taken;
  logic            pred_ready;
  logic            res_valid;
  logic            res_taken;
  logic            res_ready;
  logic            flush;
  logic            mispredict;
  logic [PC_W-1:0] mispredict_pc;
  logic [3:0]      occupancy;
  logic [CNT_W-1:0] total_count;
  logic [CNT_W-1:0] mispredict_count;

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .pred_ready       (pred_ready),
    .res_valid        (res_valid),
    .res_taken        (res_taken),
    .res_ready        (res_ready),
    .flush            (flush),
    .mispredict       (mispredict),
    .mispredict_pc    (mispredict_pc),
    .occupancy        (occupancy),
    .total_count      (total_count),
    .mispredict_count (mispredict_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // Reference model state
  logic [PC_W:0]   mq[$];     // {pc, taken}
  logic [PC_W-1:0] exp_q[$];  // expected mispredict pulses (pc)
  int              m_tot = 0;
  int              m_mc  = 0;
  int              m_mpc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               nm, act, act, exp, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances at the same rising edge.
  task automatic step(input logic pv, input logic [PC_W-1:0] pc, input logic pt,
                      input logic rv, input logic rt, input logic fl,
                      input logic rst_n);
    logic          do_push;
    logic          do_pop;
    logic [PC_W:0] e;
    pred_valid = pv;
    pred_pc    = pc;
    pred_taken = pt;
    res_valid  = rv;
    res_taken  = rt;
    flush      = fl;
    reset      = rst_n;
    @(posedge clock);
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      m_tot = 0;
      m_mc  = 0;
      m_mpc = 0;
    end else begin
      do_pop  = rv && (mq.size() != 0) && !fl;
      do_push = pv && (mq.size() != DEPTH) && !fl;
      if (do_pop) begin
        e = mq.pop_front();
        if (m_tot != CMAX) m_tot++;
        if (e[0] != rt) begin
          if (m_mc != CMAX) m_mc++;
          m_mpc = int'(e[PC_W:1]);
          exp_q.push_back(e[PC_W:1]);
        end
      end
      if (do_push) mq.push_back({pc, pt});
      if (fl) mq.delete();
    end
    #1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compares the DUT against the model away from the active edge.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("occupancy", int'(occupancy), mq.size());
      chk("pred_ready", int'(pred_ready), int'(mq.size() != DEPTH));
      chk("res_ready", int'(res_ready), int'(mq.size() != 0));
      chk("total_count", int'(total_count), m_tot);
      chk("mispredict_count", int'(mispredict_count), m_mc);
      chk("mispredict_pc_hold", int'(mispredict_pc), m_mpc);
      if (exp_q.size() != 0) begin
        chk("mispredict_pulse", int'(mispredict), 1);
        chk("mispredict_pulse_pc", int'(mispredict_pc), int'(exp_q.pop_front()));
      end else begin
        chk("no_mispredict", int'(mispredict), 0);
      end
    end
  end

  initial begin
    pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0; flush = 1'b0; reset = 1'b0;

    // Reset, with push/pop requests that must be ignored
    step(1'b1, 10'h3FF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_pred_ready", int'(pred_ready), 1);
    chk("rst_res_ready", int'(res_ready), 0);
    chk("rst_total", int'(total_count), 0);
    chk("rst_mispredict_pc", int'(mispredict_pc), 0);

    // Fill: pc 0x010..0x017, taken = pc[0]
    for (int i = 0; i < 8; i++) step(1'b1, 10'(16 + i), 1'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fill_occupancy", int'(occupancy), 8);
    chk("fill_pred_ready", int'(pred_ready), 0);
    step(1'b1, 10'h018, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ninth_push_refused", int'(occupancy), 8);

    // Full plus pop: head 0x010 (N) resolves N, push 0x019 is lost
    step(1'b1, 10'h019, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("full_pop_occupancy", int'(occupancy), 7);
    chk("full_pop_no_pulse", int'(mispredict), 0);
    // Drain resolving T: 0x012, 0x014, 0x016 mispredict
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("drain_occupancy", int'(occupancy), 0);
    chk("drain_total", int'(total_count), 8);
    chk("drain_mcount", int'(mispredict_count), 3);
    chk("drain_last_pc", int'(mispredict_pc), 'h016);
    idle();

    // In-order resolve
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'h020, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 10'h021, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("inorder_first_no_pulse", int'(mispredict), 0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("inorder_pulse", int'(mispredict), 1);
    chk("inorder_pc", int'(mispredict_pc), 'h021);
    chk("inorder_total", int'(total_count), 2);
    chk("inorder_mcount", int'(mispredict_count), 1);
    idle();
    chk("inorder_pulse_one_cycle", int'(mispredict), 0);

    // Simultaneous push/pop at occupancy 3: head 0x030 (T) resolves N
    step(1'b1, 10'h030, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 10'h031, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 10'h032, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 10'h033, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("simul_occupancy", int'(occupancy), 3);
    chk("simul_oldest_pc", int'(mispredict_pc), 'h030);
    chk("simul_mcount", int'(mispredict_count), 2);
    // Resolve the rest correctly: 0x031 N, 0x032 T, 0x033 N
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("resolve_total", int'(total_count), 6);

    // Empty resolve with a simultaneous push
    step(1'b1, 10'h040, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("empty_res_occupancy", int'(occupancy), 1);
    chk("empty_res_total", int'(total_count), 6);
    chk("empty_res_no_pulse", int'(mispredict), 0);

    // Flush at occupancy 5, with push and mispredicting pop presented
    for (int i = 0; i < 4; i++) step(1'b1, 10'(65 + i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("preflush_occupancy", int'(occupancy), 5);
    step(1'b1, 10'h050, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("flush_occupancy", int'(occupancy), 0);
    chk("flush_total", int'(total_count), 6);
    chk("flush_mcount", int'(mispredict_count), 2);
    chk("flush_no_pulse", int'(mispredict), 0);
    // Post-flush pointers restart cleanly
    step(1'b1, 10'h051, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("postflush_pc", int'(mispredict_pc), 'h051);

    // Mid-stream reset with a mispredicting pop presented
    step(1'b1, 10'h060, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 10'h061, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("midrst_occupancy", int'(occupancy), 0);
    chk("midrst_total", int'(total_count), 0);
    chk("midrst_mcount", int'(mispredict_count), 0);
    chk("midrst_pulse", int'(mispredict), 0);

    // Saturation: 20 mispredicting pops at CNT_W=4
    step(1'b1, 10'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 10'(257 + i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("sat_total", int'(total_count), 15);
    chk("sat_mcount", int'(mispredict_count), 15);
    chk("sat_occupancy", int'(occupancy), 1);
    idle();
    idle();

    mon_en = 1'b0;
    chk("pending_pulses", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
